// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: load-use stall, branch/jump flush, memory wait, forwarding
module hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_jump,
  input  logic                  ex_branch_taken,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  flush,
  output logic                  bubble_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } rec_t;

  state_t state_q, state_d;
  rec_t   ex_q, mem_q, wb_q, id_rec;
  logic   load_use, advance;
  logic   pc_en_c, ifid_en_c, flush_c, bubble_c;

  assign id_rec = {id_dest, id_reg_write, id_is_load, id_rs, id_rt};

  // A load in EX whose result the ID instruction needs; $0 never hazards.
  assign load_use = ex_q.is_load && (ex_q.dest != '0) &&
                    ((id_uses_rs && (id_rs == ex_q.dest)) ||
                     (id_uses_rt && (id_rt == ex_q.dest)));

  // Forward select: the younger producer in MEM beats the older one in WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                         input rec_t mem_r, input rec_t wb_r);
    if (mem_r.reg_write && (mem_r.dest != '0) && (mem_r.dest == src))
      return 2'b10;
    else if (wb_r.reg_write && (wb_r.dest != '0) && (wb_r.dest == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_q.rs, mem_q, wb_q);
  assign fwd_b = fwd_sel(ex_q.rt, mem_q, wb_q);

  // Per-cycle priority: memory wait, then wrong-path kill, then load-use, then jump.
  // The second flush slot outranks load-use because the ID instruction is wrong-path.
  always_comb begin
    pc_en_c   = 1'b1;
    ifid_en_c = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    advance   = 1'b1;
    state_d   = RUN;
    if (!mem_ready) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      advance   = 1'b0;
      state_d   = MEM_WAIT;
    end else if (ex_branch_taken || (state_q == FLUSH)) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      state_d  = ex_branch_taken ? FLUSH : RUN;
    end else if (load_use) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      bubble_c  = 1'b1;
      state_d   = LOAD_STALL;
    end else if (id_is_jump) begin
      state_d = FLUSH;
    end
  end

  // Reset overrides the enables and kills immediately, independent of the clock.
  assign pc_en     = pc_en_c   | ~rst_n;
  assign ifid_en   = ifid_en_c | ~rst_n;
  assign flush     = flush_c   &  rst_n;
  assign bubble_ex = bubble_c  &  rst_n;
  assign state     = state_q;

  // State register and shadow pipeline; records hold while memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        ex_q  <= (flush_c || bubble_c) ? '0 : id_rec;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed check of hazard_unit against a pipeline model
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_is_load, id_is_jump;
  logic       ex_branch_taken, mem_ready;
  logic       pc_en, ifid_en, flush, bubble_ex;
  logic [1:0] fwd_a, fwd_b, state;

  int total = 0;
  int bad   = 0;

  hazard_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_is_jump(id_is_jump), .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .flush(flush), .bubble_ex(bubble_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dest;
    bit rw;
    bit ld;
    int rs;
    int rt;
  } ins_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  ins_t pipe[3];
  int   m_state;
  int   e_pc, e_ifid, e_flush, e_bub, e_fa, e_fb, e_next;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{dest: 0, rw: 0, ld: 0, rs: 0, rt: 0};
    m_state = 0;
  endtask

  function automatic int fwd_of(input int src);
    // Search youngest-first among MEM then WB producers.
    for (int k = 1; k < 3; k++)
      if (pipe[k].rw && pipe[k].dest != 0 && pipe[k].dest == src) return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_eval();
    bit lu;
    lu = pipe[0].ld && pipe[0].dest != 0 &&
         ((id_uses_rs && int'(id_rs) == pipe[0].dest) || (id_uses_rt && int'(id_rt) == pipe[0].dest));
    e_fa = fwd_of(pipe[0].rs);
    e_fb = fwd_of(pipe[0].rt);
    e_pc = 1; e_ifid = 1; e_flush = 0; e_bub = 0; e_next = 0;
    if (!rst_n) begin
      e_fa = 0; e_fb = 0;
    end else if (!mem_ready) begin
      e_pc = 0; e_ifid = 0; e_next = 3;
    end else if (ex_branch_taken || m_state == 2) begin
      e_flush = 1; e_bub = 1; e_next = ex_branch_taken ? 2 : 0;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_bub = 1; e_next = 1;
    end else begin
      e_next = id_is_jump ? 2 : 0;
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_state = e_next;
      if (mem_ready) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (e_flush || e_bub) pipe[0] = '{dest: 0, rw: 0, ld: 0, rs: 0, rt: 0};
        else pipe[0] = '{dest: int'(id_dest), rw: id_reg_write, ld: id_is_load,
                         rs: int'(id_rs), rt: int'(id_rt)};
      end
    end
  endtask

  task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                        input int dest, input bit rw, input bit ld, input bit jmp);
    id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_dest = 5'(dest); id_reg_write = rw; id_is_load = ld; id_is_jump = jmp;
  endtask

  task automatic tick();
    #1;
    model_eval();
    check("pc_en", pc_en, e_pc);
    check("ifid_en", ifid_en, e_ifid);
    check("flush", flush, e_flush);
    check("bubble_ex", bubble_ex, e_bub);
    check("fwd_a", fwd_a, e_fa);
    check("fwd_b", fwd_b, e_fb);
    check("state", state, (!rst_n) ? 0 : m_state);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  int saved_fa, saved_fb;

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 1'b0;
    mem_ready = 1'b1;
    model_reset();
    #1;
    check("rst_pc_en", pc_en, 1);
    check("rst_flush", flush, 0);
    check("rst_state", state, 0);
    check("rst_fwd_a", fwd_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // lw $2 then add $3,$2,$4: one stall cycle, then WB forward
    set_id(1, 0, 1, 0, 2, 1, 1, 0); tick();
    set_id(2, 4, 1, 1, 3, 1, 0, 0);
    #1; check("lu_pc_en", pc_en, 0); check("lu_bubble", bubble_ex, 1);
    tick();
    #1; check("lu_release_pc_en", pc_en, 1); check("lu_state", state, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("lu_fwd_a", fwd_a, 1);
    tick();

    // add $5,$1,$1 then sub $6,$5,$5: MEM forward both operands
    set_id(1, 1, 1, 1, 5, 1, 0, 0); tick();
    set_id(5, 5, 1, 1, 6, 1, 0, 0);
    #1; check("alu_no_stall", pc_en, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("alu_fwd_a", fwd_a, 2); check("alu_fwd_b", fwd_b, 2);
    tick();

    // branch taken: two flush cycles, state 00 -> 10 -> 00
    ex_branch_taken = 1'b1;
    #1; check("br_flush0", flush, 1); check("br_state0", state, 0);
    tick();
    ex_branch_taken = 1'b0;
    #1; check("br_flush1", flush, 1); check("br_bubble1", bubble_ex, 1); check("br_state1", state, 2);
    tick();
    #1; check("br_flush2", flush, 0); check("br_state2", state, 0);
    tick();

    // memory wait three cycles with lw in MEM
    set_id(4, 0, 1, 0, 4, 1, 0, 0); tick();
    set_id(4, 0, 1, 0, 2, 1, 1, 0); tick();
    set_id(1, 1, 1, 1, 7, 1, 0, 0); tick();
    mem_ready = 1'b0;
    #1; saved_fa = fwd_a; saved_fb = fwd_b;
    for (int i = 0; i < 3; i++) begin
      #1; check("mw_pc_en", pc_en, 0);
      check("mw_fwd_a", fwd_a, saved_fa); check("mw_fwd_b", fwd_b, saved_fb);
      if (i > 0) check("mw_state", state, 3);
      tick();
    end
    mem_ready = 1'b1;
    #1; check("mw_resume_pc_en", pc_en, 1); check("mw_resume_state", state, 3);
    tick();

    // lw $0 then add $3,$0,$0: register zero never stalls or forwards
    set_id(1, 0, 1, 0, 0, 1, 1, 0); tick();
    set_id(0, 0, 1, 1, 3, 1, 0, 0);
    #1; check("r0_pc_en", pc_en, 1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("r0_fwd_a", fwd_a, 0); check("r0_fwd_b", fwd_b, 0);
    tick();

    // reset pulsed mid-FLUSH
    ex_branch_taken = 1'b1; tick();
    ex_branch_taken = 1'b0;
    #1; rst_n = 1'b0;
    #1; check("rstf_flush", flush, 0); check("rstf_bubble", bubble_ex, 0);
    check("rstf_state", state, 0); check("rstf_pc_en", pc_en, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1; check("rstf_after_flush", flush, 0);
    tick();

    // randomized traffic with small register numbers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 5) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: REG_ADDR_W, 5, register-specifier width.
REQ-002 Port: clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: id_rs  input  5  rs field of the instruction in ID.
REQ-005 Port: id_rt  input  5  rt field of the instruction in ID.
REQ-006 Port: id_uses_rs / id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 Port: id_dest  input  5  destination register selected in ID (rd/rt/31).
REQ-008 Port: id_reg_write  input  1  ID instruction writes the register file.
REQ-009 Port: id_is_load  input  1  ID instruction is lw/lb.
REQ-010 Port: id_is_jump  input  1  ID instruction is j/jal/jr (redirects the PC from ID).
REQ-011 Port: ex_branch_taken  input  1  beq/bne in EX resolved taken.
REQ-012 Port: mem_ready  input  1  data memory has completed its access this cycle.
REQ-013 Port: pc_en / ifid_en  output  1 each  PC and IF/ID register load enables.
REQ-014 Port: flush  output  1  kills the ID instruction; drives the decode controller's flush input.
REQ-015 Port: bubble_ex  output  1  loads a NOP into ID/EX.
REQ-016 Port: fwd_a / fwd_b  output  2 each  EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-017 Port: state  output  2  current FSM state, for debug.

Function
REQ-018 Shadow records for EX, MEM and WB SHALL hold {dest, reg_write, is_load, rs, rt}; a bubble has reg_write=0 and is_load=0.
REQ-019 Advance (mem_ready=1, no stall): EX<-ID record (bubble if flush or bubble_ex), MEM<-EX, WB<-MEM.
REQ-020 States: RUN=00, LOAD_STALL=01, FLUSH=10, MEM_WAIT=11.
REQ-021 Priority per cycle: mem_ready=0 > ex_branch_taken > load-use > id_is_jump.
REQ-022 mem_ready=0: pc_en=0, ifid_en=0, bubble_ex=0, flush=0; all shadow records hold; enter MEM_WAIT; remain there until mem_ready=1, then return to RUN with outputs evaluated combinationally that cycle.
REQ-023 Load-use hazard: EX.is_load=1, EX.dest!=0, and (id_uses_rs and id_rs==EX.dest, or id_uses_rt and id_rt==EX.dest).
REQ-024 On a load-use hazard: pc_en=0, ifid_en=0, bubble_ex=1 for exactly one cycle (LOAD_STALL); EX/MEM/WB advance; the next cycle re-evaluates the hazard against the new EX record.
REQ-025 ex_branch_taken=1: flush=1 and bubble_ex=1 that cycle, pc_en=1, ifid_en=1; enter FLUSH.
REQ-026 FLUSH: flush=1 and bubble_ex=1 for one more cycle (wrong-path fetch now in ID), then RUN; total flush length 2 cycles.
REQ-027 ex_branch_taken together with a load-use hazard: the branch flush wins; no stall cycle is inserted.
REQ-028 id_is_jump=1 with no higher-priority event: flush=1 and bubble_ex=1 in the following cycle only (one wrong-path slot); a jr with a load-use hazard stalls first and jumps after the stall.
REQ-029 Forwarding fwd_a: 10 if MEM.reg_write, MEM.dest!=0 and MEM.dest==EX.rs; else 01 if WB.reg_write, WB.dest!=0 and WB.dest==EX.rs; else 00. fwd_b is the same using EX.rt.
REQ-030 Register 0 SHALL never cause a stall or a forward.
REQ-031 fwd_a/fwd_b SHALL be combinational from the shadow records and valid in every state, including MEM_WAIT.

Reset
REQ-032 rst_n=0 SHALL immediately clear all shadow records to bubbles and force state=RUN, pc_en=1, ifid_en=1, flush=0, bubble_ex=0, fwd_a=00, fwd_b=00.
REQ-033 Reset asserted during LOAD_STALL, FLUSH or MEM_WAIT SHALL abort the sequence; no residual stall or flush after release.

Verification
REQ-034 lw $2 followed by add $3,$2,$4 -> one cycle of pc_en=0, ifid_en=0, bubble_ex=1; then fwd_a=01 for the add in EX.
REQ-035 add $5,$1,$1 followed by sub $6,$5,$5 -> no stall; fwd_a=10 and fwd_b=10 when sub is in EX.
REQ-036 beq taken in EX -> flush=1 and bubble_ex=1 for exactly 2 cycles; state 00->10->00.
REQ-037 mem_ready held low 3 cycles during a lw in MEM -> pc_en=0 for 3 cycles, state=11, fwd outputs stable; normal flow resumes on the cycle mem_ready=1.
REQ-038 lw $0 followed by add $3,$0,$0 -> no stall, fwd_a=fwd_b=00.
REQ-039 rst_n pulsed low mid-FLUSH -> outputs return to their reset values asynchronously; first cycle after release flush=0.
